// File: rtl/pipe_pkg.sv
// Shared constants and types for the inter-stage pipeline registers.
package pipe_pkg;

  // Exception code meaning "no exception"
  localparam int EXC_NONE = 0;

  // Default exception code width
  localparam int EXC_W_DEF = 5;

  // PC loaded when a stage is flushed for an exception/interrupt
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  // PC held by every stage register after reset
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Payload field offsets (LSB positions) shared by the D/E, E/M and M/W instances
  localparam int PL_INSTR_LSB = 0;
  localparam int PL_INSTR_W   = 32;
  localparam int PL_OPA_LSB   = 32;
  localparam int PL_OPB_LSB   = 64;
  localparam int PL_OP_W      = 32;
  localparam int PL_IMM_LSB   = 96;
  localparam int PL_IMM_W     = 16;
  localparam int PL_CTRL_LSB  = 112;
  localparam int PL_CTRL_W    = 16;

  // What a stage register does in a given (non-reset) cycle
  typedef enum logic [1:0] {
    MODE_LOAD  = 2'd0,
    MODE_STALL = 2'd1,
    MODE_HOLD  = 2'd2,
    MODE_FLUSH = 2'd3
  } stage_mode_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/data bundle between a pipeline stage register and its surroundings.
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 128,
  parameter int ADDR_W    = 32,
  parameter int EXC_W     = 5,
  parameter int CNT_W     = 16
);
  logic                 en;
  logic                 stall;
  logic                 req;
  logic                 in_valid;
  logic [ADDR_W-1:0]    in_pc;
  logic                 in_bd;
  logic [EXC_W-1:0]     in_exc;
  logic [EXC_W-1:0]     local_exc;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 cnt_clr;
  logic                 out_valid;
  logic [ADDR_W-1:0]    out_pc;
  logic                 out_bd;
  logic [EXC_W-1:0]     out_exc;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [CNT_W-1:0]     bubble_cnt;

  // Upstream/control side: drives the stage inputs, observes the stage outputs
  modport master (
    output en, stall, req, in_valid, in_pc, in_bd, in_exc, local_exc, in_payload, cnt_clr,
    input  out_valid, out_pc, out_bd, out_exc, out_payload, bubble_cnt
  );

  // The stage register itself
  modport slave (
    input  en, stall, req, in_valid, in_pc, in_bd, in_exc, local_exc, in_payload, cnt_clr,
    output out_valid, out_pc, out_bd, out_exc, out_payload, bubble_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used to count inserted bubbles.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count up on inc, stick at all-ones, clear has priority over increment
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid, PC, delay-slot flag, merged
// exception code and opaque payload, with hold, bubble and flush modes.
module pipe_stage_reg #(
  parameter int                PAYLOAD_W  = 128,
  parameter int                ADDR_W     = 32,
  parameter int                EXC_W      = pipe_pkg::EXC_W_DEF,
  parameter logic [ADDR_W-1:0] HANDLER_PC = ADDR_W'(pipe_pkg::HANDLER_PC),
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(pipe_pkg::RESET_PC),
  parameter int                CNT_W      = 16
) (
  input logic               clk,
  input logic               reset,
  pipe_stage_reg_if.slave   bus
);
  import pipe_pkg::*;

  logic                 r_valid;
  logic [ADDR_W-1:0]    r_pc;
  logic                 r_bd;
  logic [EXC_W-1:0]     r_exc;
  logic [PAYLOAD_W-1:0] r_payload;

  stage_mode_e          w_mode;
  logic [EXC_W-1:0]     w_merged_exc;
  logic                 w_cnt_inc;
  logic [CNT_W-1:0]     w_bubble_cnt;

  // Cycle mode: flush beats hold, hold beats bubble, bubble beats load
  always_comb begin
    w_mode = MODE_LOAD;
    if (bus.req) begin
      w_mode = MODE_FLUSH;
    end else if (!bus.en) begin
      w_mode = MODE_HOLD;
    end else if (bus.stall) begin
      w_mode = MODE_STALL;
    end
  end

  // Earliest stage's exception wins; a non-valid slot never carries one
  assign w_merged_exc = !bus.in_valid ? EXC_W'(EXC_NONE) :
                        (bus.in_exc != EXC_W'(EXC_NONE)) ? bus.in_exc : bus.local_exc;

  // Stage state update; bubbles keep PC/BD so a later exception reports a correct EPC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_pc      <= RESET_PC;
      r_bd      <= 1'b0;
      r_exc     <= '0;
      r_payload <= '0;
    end else begin
      case (w_mode)
        MODE_FLUSH: begin
          r_valid   <= 1'b0;
          r_pc      <= HANDLER_PC;
          r_bd      <= 1'b0;
          r_exc     <= '0;
          r_payload <= '0;
        end
        MODE_STALL: begin
          r_valid   <= 1'b0;
          r_pc      <= bus.in_pc;
          r_bd      <= bus.in_bd;
          r_exc     <= '0;
          r_payload <= '0;
        end
        MODE_LOAD: begin
          r_valid   <= bus.in_valid;
          r_pc      <= bus.in_pc;
          r_bd      <= bus.in_bd;
          r_exc     <= w_merged_exc;
          r_payload <= bus.in_payload;
        end
        default: begin
          // MODE_HOLD: keep everything
        end
      endcase
    end
  end

  // Only a real bubble counts; hold and flush cycles leave the counter alone
  assign w_cnt_inc = (w_mode == MODE_STALL);

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.cnt_clr),
    .inc   (w_cnt_inc),
    .q     (w_bubble_cnt)
  );

  assign bus.out_valid   = r_valid;
  assign bus.out_pc      = r_pc;
  assign bus.out_bd      = r_bd;
  assign bus.out_exc     = r_exc;
  assign bus.out_payload = r_payload;
  assign bus.bubble_cnt  = w_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance and a CNT_W=2 instance
// for counter saturation.
module tb_pipe_stage_reg;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pipe_stage_reg_if #(.CNT_W(16)) bus0 ();
  pipe_stage_reg_if #(.CNT_W(2))  bus1 ();

  pipe_stage_reg #(.CNT_W(16)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  pipe_stage_reg #(.CNT_W(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string what);
    @(posedge clk);
    #1;
    $display("[%0t] %s: valid=%0b pc=%h bd=%0b exc=%0d payload=%0h cnt0=%0d cnt1=%0d",
             $time, what, bus0.out_valid, bus0.out_pc, bus0.out_bd, bus0.out_exc,
             bus0.out_payload, bus0.bubble_cnt, bus1.bubble_cnt);
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Idle inputs
    reset = 1'b1;
    bus0.en = 1'b0; bus0.stall = 1'b0; bus0.req = 1'b0; bus0.in_valid = 1'b0;
    bus0.in_pc = '0; bus0.in_bd = 1'b0; bus0.in_exc = '0; bus0.local_exc = '0;
    bus0.in_payload = '0; bus0.cnt_clr = 1'b0;
    bus1.en = 1'b0; bus1.stall = 1'b0; bus1.req = 1'b0; bus1.in_valid = 1'b0;
    bus1.in_pc = '0; bus1.in_bd = 1'b0; bus1.in_exc = '0; bus1.local_exc = '0;
    bus1.in_payload = '0; bus1.cnt_clr = 1'b0;

    // Reset with en=0
    tick("reset");
    chk("rst_pc",      bus0.out_pc, 32'h0000_0000);
    chk("rst_valid",   bus0.out_valid, 1'b0);
    chk("rst_exc",     bus0.out_exc, 5'd0);
    chk("rst_bd",      bus0.out_bd, 1'b0);
    chk("rst_payload", bus0.out_payload, 128'h0);
    chk("rst_cnt",     bus0.bubble_cnt, 16'd0);
    chk("rst_cnt1",    bus1.bubble_cnt, 2'd0);
    reset = 1'b0;

    // Load: local exception used when upstream has none
    bus0.en = 1'b1; bus0.in_valid = 1'b1; bus0.in_pc = 32'h3004;
    bus0.in_payload = 128'hDEADBEEF; bus0.in_exc = 5'd0; bus0.local_exc = 5'd10;
    tick("load_local_exc");
    chk("ld_valid",   bus0.out_valid, 1'b1);
    chk("ld_pc",      bus0.out_pc, 32'h3004);
    chk("ld_exc",     bus0.out_exc, 5'd10);
    chk("ld_payload", bus0.out_payload, 128'hDEADBEEF);

    // Load: earlier-stage exception wins
    bus0.in_exc = 5'd4;
    tick("load_in_exc");
    chk("ld_exc_first", bus0.out_exc, 5'd4);

    // Load with in_valid=0: exception dropped, payload still loaded
    bus0.in_valid = 1'b0; bus0.in_exc = 5'd0; bus0.local_exc = 5'd7;
    bus0.in_payload = 128'h55; bus0.in_pc = 32'h3000;
    tick("load_invalid");
    chk("inv_valid",   bus0.out_valid, 1'b0);
    chk("inv_exc",     bus0.out_exc, 5'd0);
    chk("inv_payload", bus0.out_payload, 128'h55);
    chk("inv_pc",      bus0.out_pc, 32'h3000);

    // Three bubble cycles, PC/BD preserved
    bus0.stall = 1'b1; bus0.in_valid = 1'b1; bus0.in_pc = 32'h3008; bus0.in_bd = 1'b1;
    bus0.in_payload = 128'hCAFE; bus0.in_exc = 5'd3;
    for (int i = 1; i <= 3; i++) begin
      tick("stall");
      chk("st_valid",   bus0.out_valid, 1'b0);
      chk("st_payload", bus0.out_payload, 128'h0);
      chk("st_pc",      bus0.out_pc, 32'h3008);
      chk("st_bd",      bus0.out_bd, 1'b1);
      chk("st_exc",     bus0.out_exc, 5'd0);
      chk("st_cnt",     bus0.bubble_cnt, 16'(i));
    end

    // Stall with en=0: hold, no count
    bus0.en = 1'b0; bus0.in_pc = 32'h9999; bus0.in_bd = 1'b0;
    tick("stall_hold");
    chk("sh_cnt", bus0.bubble_cnt, 16'd3);
    chk("sh_pc",  bus0.out_pc, 32'h3008);
    chk("sh_bd",  bus0.out_bd, 1'b1);

    // Flush with stall and en=0 together
    bus0.req = 1'b1;
    tick("flush");
    chk("fl_pc",    bus0.out_pc, 32'h0000_4180);
    chk("fl_valid", bus0.out_valid, 1'b0);
    chk("fl_bd",    bus0.out_bd, 1'b0);
    chk("fl_exc",   bus0.out_exc, 5'd0);
    chk("fl_cnt",   bus0.bubble_cnt, 16'd3);
    bus0.req = 1'b0;

    // Known load, then four hold cycles with changing inputs
    bus0.en = 1'b1; bus0.stall = 1'b0; bus0.in_valid = 1'b1; bus0.in_pc = 32'h5000;
    bus0.in_bd = 1'b1; bus0.in_exc = 5'd0; bus0.local_exc = 5'd3; bus0.in_payload = 128'h1234;
    tick("load_pre_hold");
    chk("lh_pc",  bus0.out_pc, 32'h5000);
    chk("lh_exc", bus0.out_exc, 5'd3);
    bus0.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus0.in_valid = i[0]; bus0.in_pc = 32'h6000 + 32'(4 * i); bus0.in_bd = ~i[0];
      bus0.in_exc = 5'(i + 1); bus0.in_payload = 128'hA0 + 128'(i); bus0.stall = i[1];
      tick("hold");
      chk("h_valid",   bus0.out_valid, 1'b1);
      chk("h_pc",      bus0.out_pc, 32'h5000);
      chk("h_bd",      bus0.out_bd, 1'b1);
      chk("h_exc",     bus0.out_exc, 5'd3);
      chk("h_payload", bus0.out_payload, 128'h1234);
      chk("h_cnt",     bus0.bubble_cnt, 16'd3);
    end
    // Last hold inputs: valid=1, pc=0x600C, bd=0, in_exc=4, payload=0xA3, stall=1
    bus0.stall = 1'b0; bus0.en = 1'b1;
    tick("release_hold");
    chk("rl_valid",   bus0.out_valid, 1'b1);
    chk("rl_pc",      bus0.out_pc, 32'h600C);
    chk("rl_bd",      bus0.out_bd, 1'b0);
    chk("rl_exc",     bus0.out_exc, 5'd4);
    chk("rl_payload", bus0.out_payload, 128'hA3);

    // Clear wins over a simultaneous stall increment
    bus0.stall = 1'b1; bus0.cnt_clr = 1'b1;
    tick("clear_vs_stall");
    chk("clr_cnt", bus0.bubble_cnt, 16'd0);
    bus0.cnt_clr = 1'b0;
    tick("stall_after_clear");
    chk("clr_inc", bus0.bubble_cnt, 16'd1);

    // Reset in the middle of a stall
    reset = 1'b1;
    tick("reset_mid_stall");
    chk("rms_cnt",   bus0.bubble_cnt, 16'd0);
    chk("rms_pc",    bus0.out_pc, 32'h0);
    chk("rms_bd",    bus0.out_bd, 1'b0);
    chk("rms_valid", bus0.out_valid, 1'b0);
    reset = 1'b0;
    bus0.en = 1'b0; bus0.stall = 1'b0;

    // Saturation on the 2-bit counter instance: 1,2,3,3,3
    bus1.en = 1'b1; bus1.stall = 1'b1; bus1.in_pc = 32'h7000;
    for (int i = 1; i <= 5; i++) begin
      tick("sat_stall");
      chk("sat_cnt", bus1.bubble_cnt, (i < 3) ? 2'(i) : 2'd3);
    end
    bus1.cnt_clr = 1'b1;
    tick("sat_clear");
    chk("sat_clr", bus1.bubble_cnt, 2'd0);
    bus1.cnt_clr = 1'b0; bus1.en = 1'b0; bus1.stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
